// File: rtl/i2c_config_sequencer.sv
// i2c_config_sequencer
//   Programs up to NUM_DEVICES I2C chips in ascending index order through one
//   shared i2c_handler. After reset it runs an automatic pass over every device
//   when AUTO_INIT is set. A later pass can be requested over any subset of
//   devices through dev_mask. A NACK is retried MAX_RETRIES times, with a
//   RETRY_GAP back-off before each retry. Devices that still fail are reported
//   in fail_mask.
//
// Ports
//   clk, reset       : clock; synchronous active-high reset
//   start, dev_mask  : request a pass over dev_mask (accepted only when idle)
//   busy             : sequencer or handler active
//   done, error      : pass finished (level); error = any device failed
//   fail_mask        : per-device failure report of the last pass
//   dev_sel          : device currently addressed (external LUT mux select)
//   i2c_address      : slave address of dev_sel
//   i2c_stop_index   : LUT stop index of dev_sel
//   h_start          : one-cycle start pulse to the handler
//   h_busy, h_nack   : handler status

module i2c_config_sequencer #(
  parameter int unsigned                    CLK_FREQ    = 50000000,
  parameter int unsigned                    I2C_FREQ    = 100000,
  parameter int unsigned                    NUM_DEVICES = 2,
  parameter logic [7*NUM_DEVICES-1:0]       DEV_ADDRS   = {7'h5A, 7'h74},
  parameter logic [10*NUM_DEVICES-1:0]      DEV_STOP    = {10'd105, 10'd2},
  parameter int unsigned                    MAX_RETRIES = 3,
  parameter int unsigned                    RETRY_GAP   = 1000,
  parameter int unsigned                    AUTO_INIT   = 1,
  localparam int unsigned                   SEL_W       = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NUM_DEVICES-1:0] dev_mask,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [NUM_DEVICES-1:0] fail_mask,
  output logic [SEL_W-1:0]       dev_sel,
  output logic [6:0]             i2c_address,
  output logic [9:0]             i2c_stop_index,
  output logic                   h_start,
  input  logic                   h_busy,
  input  logic                   h_nack
);

  localparam int unsigned GAP_W = $clog2(RETRY_GAP + 1);

  if (NUM_DEVICES < 1 || NUM_DEVICES > 8 || MAX_RETRIES > 15 || RETRY_GAP < 1 ||
      I2C_FREQ == 0 || CLK_FREQ < 4 * I2C_FREQ) begin : g_param_check
    $error("i2c_config_sequencer: parameter out of range");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_LAUNCH,
    ST_WAIT,
    ST_RUN,
    ST_BACKOFF
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_DEVICES-1:0] pending_q, pending_d;
  logic [3:0]             retry_cnt_q, retry_cnt_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
  logic                   busy_int_q, busy_int_d;
  logic                   done_q, done_d;
  logic [NUM_DEVICES-1:0] fail_mask_q, fail_mask_d;
  logic [SEL_W-1:0]       dev_sel_q, dev_sel_d;
  logic                   h_start_q, h_start_d;
  logic [SEL_W-1:0]       first_sel;

  // Lowest set bit of pending: scan downwards so the lowest index wins.
  always_comb begin
    first_sel = '0;
    for (int unsigned k = NUM_DEVICES; k > 0; k--) begin
      if (pending_q[k-1]) first_sel = SEL_W'(k - 1);
    end
  end

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    retry_cnt_d = retry_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    busy_int_d  = busy_int_q;
    done_d      = done_q;
    fail_mask_d = fail_mask_q;
    dev_sel_d   = dev_sel_q;
    h_start_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pending_q != '0 && !h_busy) begin
          busy_int_d = 1'b1;
          state_d    = ST_SCAN;
        end else if (start) begin
          pending_d   = dev_mask;
          fail_mask_d = '0;
          done_d      = 1'b0;
          busy_int_d  = 1'b1;
          state_d     = ST_SCAN;
        end else begin
          // An auto-init pass still waiting for the handler counts as busy.
          busy_int_d = (pending_q != '0);
        end
      end
      ST_SCAN: begin
        if (pending_q == '0) begin
          done_d     = 1'b1;
          busy_int_d = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          dev_sel_d   = first_sel;
          retry_cnt_d = '0;
          state_d     = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        h_start_d = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: state_d = ST_RUN;
      ST_RUN: begin
        if (!h_busy) begin
          if (!h_nack) begin
            pending_d[dev_sel_q] = 1'b0;
            state_d              = ST_SCAN;
          end else if (retry_cnt_q < 4'(MAX_RETRIES)) begin
            retry_cnt_d = retry_cnt_q + 4'd1;
            // Counting RETRY_GAP down to zero inclusive makes the retry pulse
            // land RETRY_GAP+3 cycles after h_busy falls.
            gap_cnt_d   = GAP_W'(RETRY_GAP);
            state_d     = ST_BACKOFF;
          end else begin
            fail_mask_d[dev_sel_q] = 1'b1;
            pending_d[dev_sel_q]   = 1'b0;
            state_d                = ST_SCAN;
          end
        end
      end
      ST_BACKOFF: begin
        if (gap_cnt_q == '0) state_d = ST_LAUNCH;
        else gap_cnt_d = gap_cnt_q - GAP_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pending_q   <= (AUTO_INIT != 0) ? '1 : '0;
      retry_cnt_q <= '0;
      gap_cnt_q   <= '0;
      busy_int_q  <= 1'b1;
      done_q      <= 1'b0;
      fail_mask_q <= '0;
      dev_sel_q   <= '0;
      h_start_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      retry_cnt_q <= retry_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      busy_int_q  <= busy_int_d;
      done_q      <= done_d;
      fail_mask_q <= fail_mask_d;
      dev_sel_q   <= dev_sel_d;
      h_start_q   <= h_start_d;
    end
  end

  assign busy           = busy_int_q | h_busy;
  assign done           = done_q;
  assign error          = |fail_mask_q;
  assign fail_mask      = fail_mask_q;
  assign dev_sel        = dev_sel_q;
  assign h_start        = h_start_q;
  assign i2c_address    = DEV_ADDRS[dev_sel_q*7 +: 7];
  assign i2c_stop_index = DEV_STOP[dev_sel_q*10 +: 10];

endmodule
